alu_mul_sequencer: RTL

// - Multi-cycle unsigned N x N -> 2N shift-add multiplier. Owns no adder; it

---
 rtl/alu_mul_sequencer_if.sv | 45 ++++
 rtl/alu_mul_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if
//   Request/response bundle between the execute stage and the multi-cycle
//   multiplier sequencer.
//   Optional feature macro: SIGNED_MUL_EN (adds mul_signed).
//
//   start         requester -> sequencer   request, honoured only when idle
//   multiplicand  requester -> sequencer   operand A (N bits)
//   multiplier    requester -> sequencer   operand B (N bits)
//   mul_signed    requester -> sequencer   signed request (SIGNED_MUL_EN only)
//   busy          sequencer -> requester   iteration in progress
//   done          sequencer -> requester   one-cycle completion pulse
//   product       sequencer -> requester   {hi,lo}, 2N bits
interface alu_mul_sequencer_if #(
   parameter int N = 32
);
   logic           start;
   logic [N-1:0]   multiplicand;
   logic [N-1:0]   multiplier;
`ifdef SIGNED_MUL_EN
   logic           mul_signed;
`endif
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;

`ifdef SIGNED_MUL_EN
   modport master (
      output start, multiplicand, multiplier, mul_signed,
      input  busy, done, product
   );
   modport slave (
      input  start, multiplicand, multiplier, mul_signed,
      output busy, done, product
   );
`else
   modport master (
      output start, multiplicand, multiplier,
      input  busy, done, product
   );
   modport slave (
      input  start, multiplicand, multiplier,
      output busy, done, product
   );
`endif
endinterface

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//   Multi-cycle N x N -> 2N shift-add multiplier that borrows the shared
//   execute-stage ALU instead of owning an adder. One ALU add per RUN cycle;
//   the ALU is combinational, so its result is consumed in the same cycle.
//   Optional feature macro: SIGNED_MUL_EN (signed operands via magnitudes).
//
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high
//   bus         slave modport of alu_mul_sequencer_if (start/operands/
//               busy/done/product)
//   alu_a       out  ALU Number1
//   alu_b       out  ALU Number2
//   alu_ctrl    out  ALU AluControl, fixed ADD
//   alu_result  in   ALU Result
//   alu_flags   in   ALU flags {N,Z,C,V}; only C is used
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | waiting for start; product held
//   ST_RUN  | one add-and-shift per cycle, count 0..N-1
//   ST_DONE | done pulse for one cycle, start ignored
module alu_mul_sequencer #(
   parameter int N = 32
) (
   input  logic                clk,
   input  logic                reset,
   alu_mul_sequencer_if.slave  bus,
   output logic [N-1:0]        alu_a,
   output logic [N-1:0]        alu_b,
   output logic [2:0]          alu_ctrl,
   input  logic [N-1:0]        alu_result,
   input  logic [3:0]          alu_flags
);

   localparam int             CW     = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0]  LAST   = CW'(N - 1);
   localparam logic [CW-1:0]  ONE_C  = CW'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic [N-1:0]   hi_q, hi_d;
   logic [N-1:0]   lo_q, lo_d;
   logic [N-1:0]   mcand_q, mcand_d;
   logic [2*N-1:0] step;

`ifdef SIGNED_MUL_EN
   localparam logic [N-1:0]   ONE_N  = N'(1);
   localparam logic [2*N-1:0] ONE_2N = (2*N)'(1);
   logic           sign_q, sign_d;
   logic [N-1:0]   a_mag, b_mag;
`endif

   // V, N and Z are irrelevant for an unsigned add that can never overflow
   // 2N bits; the name keeps them out of unused-signal reports.
   logic unused_flags;
   assign unused_flags = ^{alu_flags[3:2], alu_flags[0]};

   // ALU drive: only RUN borrows the adder; otherwise present a quiet ADD 0+0.
   assign alu_ctrl = 3'b000;
   assign alu_a    = (state_q == ST_RUN) ? hi_q : '0;
   assign alu_b    = ((state_q == ST_RUN) && lo_q[0]) ? mcand_q : '0;

   assign bus.busy    = (state_q == ST_RUN);
   assign bus.done    = (state_q == ST_DONE);
   assign bus.product = {hi_q, lo_q};

   // Carry is bit N of the partial sum; the whole 2N+1-bit value shifted right
   // by one is exactly {C, sum, lo[N-1:1]}.
   assign step = {alu_flags[1], alu_result, lo_q[N-1:1]};

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      mcand_d = mcand_q;
`ifdef SIGNED_MUL_EN
      sign_d  = sign_q;
      a_mag   = bus.multiplicand;
      b_mag   = bus.multiplier;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_RUN;
               count_d = '0;
               hi_d    = '0;
`ifdef SIGNED_MUL_EN
               if (bus.mul_signed) begin
                  // The most-negative value negates to 2^(N-1), which is
                  // still exact as an unsigned N-bit magnitude.
                  if (bus.multiplicand[N-1]) a_mag = ~bus.multiplicand + ONE_N;
                  if (bus.multiplier[N-1])   b_mag = ~bus.multiplier + ONE_N;
                  sign_d = bus.multiplicand[N-1] ^ bus.multiplier[N-1];
               end else begin
                  sign_d = 1'b0;
               end
               mcand_d = a_mag;
               lo_d    = b_mag;
`else
               mcand_d = bus.multiplicand;
               lo_d    = bus.multiplier;
`endif
            end
         end
         ST_RUN: begin
            count_d      = count_q + ONE_C;
            {hi_d, lo_d} = step;
            if (count_q == LAST) begin
               state_d = ST_DONE;
`ifdef SIGNED_MUL_EN
               // Sign is applied on the final iteration so latency matches
               // the unsigned case.
               if (sign_q) {hi_d, lo_d} = ~step + ONE_2N;
`endif
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         mcand_q <= '0;
`ifdef SIGNED_MUL_EN
         sign_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         mcand_q <= mcand_d;
`ifdef SIGNED_MUL_EN
         sign_q  <= sign_d;
`endif
      end
   end

endmodule
